// File: rtl/i2c_master_byte_seq.sv
// rtl/i2c_master_byte_seq.sv - I2C master byte sequencer driving the bit controller
// Turns one START/WRITE/READ/STOP byte command into a handshaked series of bit commands.
module i2c_master_byte_seq #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  input  logic          cmd_start,
  input  logic          cmd_stop,
  input  logic          cmd_write,
  input  logic          cmd_read,
  input  logic          ack_in,
  input  logic [DW-1:0] din,
  output logic          cmd_ready,
  output logic          done,
  output logic          ack_out,
  output logic [DW-1:0] dout,
  output logic          i2c_al,
  output logic [3:0]    bit_cmd,
  input  logic          bit_cmd_ack,
  input  logic          bit_al,
  output logic          bit_txd,
  input  logic          bit_rxd
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  localparam logic [3:0] BC_NOP   = 4'b0000;
  localparam logic [3:0] BC_START = 4'b0001;
  localparam logic [3:0] BC_STOP  = 4'b0010;
  localparam logic [3:0] BC_WRITE = 4'b0100;
  localparam logic [3:0] BC_READ  = 4'b1000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_ACK,
    S_STOP
  } state_t;

  state_t          r_state;
  logic            r_stop;
  logic            r_write;
  logic            r_read;
  logic            r_ack_in;
  logic [DW-1:0]   r_sr;
  logic [CW-1:0]   r_cnt;
  logic [3:0]      r_bit_cmd;
  logic            r_bit_txd;
  logic            r_done;
  logic            r_al;
  logic            r_ack_out;
  logic [DW-1:0]   r_dout;

  state_t          w_state_nxt;
  logic            w_load;
  logic            w_shift;
  logic            w_capture;
  logic            w_done_nxt;
  logic            w_al_nxt;
  logic            w_write_nxt;
  logic            w_read_nxt;
  logic            w_ack_in_nxt;
  logic [DW-1:0]   w_sr_nxt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [3:0]      w_bit_cmd_nxt;
  logic            w_bit_txd_nxt;

  assign cmd_ready = (r_state == S_IDLE);
  assign done      = r_done;
  assign i2c_al    = r_al;
  assign ack_out   = r_ack_out;
  assign dout      = r_dout;
  assign bit_cmd   = r_bit_cmd;
  assign bit_txd   = r_bit_txd;

  // Arbitration loss is checked before the ack so it wins when both arrive together.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_capture   = 1'b0;
    w_done_nxt  = 1'b0;
    w_al_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_al_nxt = bit_al;
        if (cmd_valid) begin
          w_load = 1'b1;
          if (cmd_start) begin
            w_state_nxt = S_START;
          end else if (cmd_write || cmd_read) begin
            w_state_nxt = S_DATA;
          end else if (cmd_stop) begin
            w_state_nxt = S_STOP;
          end else begin
            w_done_nxt = 1'b1;
          end
        end
      end
      default: begin
        if (bit_al) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
          w_al_nxt    = 1'b1;
        end else if (bit_cmd_ack) begin
          case (r_state)
            S_START: begin
              if (r_write || r_read) begin
                w_state_nxt = S_DATA;
              end else if (r_stop) begin
                w_state_nxt = S_STOP;
              end else begin
                w_state_nxt = S_IDLE;
                w_done_nxt  = 1'b1;
              end
            end
            S_DATA: begin
              w_shift = 1'b1;
              if (r_cnt == '0) begin
                w_state_nxt = S_ACK;
              end
            end
            S_ACK: begin
              w_capture = 1'b1;
              if (r_stop) begin
                w_state_nxt = S_STOP;
              end else begin
                w_state_nxt = S_IDLE;
                w_done_nxt  = 1'b1;
              end
            end
            default: begin
              w_state_nxt = S_IDLE;
              w_done_nxt  = 1'b1;
            end
          endcase
        end
      end
    endcase
  end

  always_comb begin
    w_write_nxt  = w_load ? cmd_write : r_write;
    w_read_nxt   = w_load ? (cmd_read & ~cmd_write) : r_read;
    w_ack_in_nxt = w_load ? ack_in : r_ack_in;
    w_sr_nxt     = r_sr;
    w_cnt_nxt    = r_cnt;
    if (w_load) begin
      w_sr_nxt  = din;
      w_cnt_nxt = CW'(DW - 1);
    end else if (w_shift) begin
      w_sr_nxt = {r_sr[DW-2:0], (r_write ? 1'b0 : bit_rxd)};
      if (r_cnt != '0) begin
        w_cnt_nxt = r_cnt - 1'b1;
      end
    end
  end

  // Bit command is derived from the state being entered, so it is registered with it.
  always_comb begin
    w_bit_cmd_nxt = BC_NOP;
    w_bit_txd_nxt = 1'b1;
    case (w_state_nxt)
      S_START: w_bit_cmd_nxt = BC_START;
      S_DATA: begin
        if (w_write_nxt) begin
          w_bit_cmd_nxt = BC_WRITE;
          w_bit_txd_nxt = w_sr_nxt[DW-1];
        end else begin
          w_bit_cmd_nxt = BC_READ;
        end
      end
      S_ACK: begin
        if (w_write_nxt) begin
          w_bit_cmd_nxt = BC_READ;
        end else begin
          w_bit_cmd_nxt = BC_WRITE;
          w_bit_txd_nxt = w_ack_in_nxt;
        end
      end
      S_STOP:  w_bit_cmd_nxt = BC_STOP;
      default: w_bit_cmd_nxt = BC_NOP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stop    <= 1'b0;
      r_write   <= 1'b0;
      r_read    <= 1'b0;
      r_ack_in  <= 1'b0;
      r_sr      <= '0;
      r_cnt     <= '0;
      r_bit_cmd <= BC_NOP;
      r_bit_txd <= 1'b1;
      r_done    <= 1'b0;
      r_al      <= 1'b0;
      r_ack_out <= 1'b0;
      r_dout    <= '0;
    end else begin
      if (w_load) begin
        r_stop <= cmd_stop;
      end
      r_write   <= w_write_nxt;
      r_read    <= w_read_nxt;
      r_ack_in  <= w_ack_in_nxt;
      r_sr      <= w_sr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_cmd <= w_bit_cmd_nxt;
      r_bit_txd <= w_bit_txd_nxt;
      r_done    <= w_done_nxt;
      r_al      <= w_al_nxt;
      if (w_capture) begin
        r_ack_out <= bit_rxd;
        if (r_read) begin
          r_dout <= r_sr;
        end
      end
    end
  end

endmodule
